muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer between the core's M-extension issue port and the two arithmetic units: the pipelined multiplier (multiplier_top_V2) and the iterative divider. It takes one RV32M operation at a time over a valid/ready handshake and drives the selected unit's enable, operand and mode lines. It resolves RISC-V divide-by-zero and signed-overflow cases itself, without starting the divider. It returns the 32-bit result with the requester's tag, plus a timeout error if a unit never reports done.

## Interface
- TAG_W, 5: width of the destination tag carried request→response
- TIMEOUT_CYC, 64: cycles in *_RUN before the op is aborted with error
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  controller can accept
- req_funct3_i  in  3  RV32M funct3
- req_op_a_i  in  32  rs1 value
- req_op_b_i  in  32  rs2 value
- req_tag_i  in  TAG_W  destination tag
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_result_o  out  32  result
- rsp_tag_o  out  TAG_W  echoed tag
- rsp_err_o  out  1  op timed out; result is 0
- mul_en_o, mul_signed_a_o, mul_signed_b_o, mul_upper_o  out  1 each  multiplier control
- mul_op_a_o, mul_op_b_o  out  32  multiplier operands
- mul_result_i  in  32; mul_done_i  in  1  multiplier result and done
- div_en_o, div_signed_o, div_rem_o  out  1 each  divider control
- div_op_a_o, div_op_b_o  out  32  divider operands
- div_result_i  in  32; div_done_i  in  1  divider result and done

## Operation
- States: IDLE, MUL_RUN, DIV_RUN, RESP.
- req_ready_o = (state==IDLE). A request is accepted on a clock edge where req_valid_i and req_ready_o are both high.
- On accept, funct3, operands and tag are latched. Unit operand and mode outputs come from these latches and stay stable until the op leaves *_RUN.
- funct3 decode:
  - 000 MUL: signed_a=1, signed_b=1, upper=0
  - 001 MULH: 1, 1, upper=1
  - 010 MULHSU: 1, 0, upper=1
  - 011 MULHU: 0, 0, upper=1
  - 100 DIV: signed=1, rem=0
  - 101 DIVU: signed=0, rem=0
  - 110 REM: signed=1, rem=1
  - 111 REMU: signed=0, rem=1
- funct3[2]=0 → MUL_RUN. mul_en_o = (state==MUL_RUN).
- funct3[2]=1 with a special case → RESP directly, div_en_o never asserted:
  - op_b==0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op_a.
  - signed DIV/REM with op_a==0x80000000 and op_b==0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- Otherwise funct3[2]=1 → DIV_RUN. div_en_o = (state==DIV_RUN).
- In *_RUN, the edge that samples the unit's done high captures its result → RESP, err=0.
- Done from the unit not selected for the current op is ignored.
- Timeout counter clears on entering *_RUN and increments each cycle there. On reaching TIMEOUT_CYC → RESP with err=1 and result 0. The enable drops on that same edge.
- RESP: rsp_valid_o=1; result, tag and err are held stable until rsp_ready_i. The edge sampling rsp_ready_i high → IDLE.
- Reset, async and at any time including mid-op: state=IDLE, counter=0, all data registers=0. Every output then reads 0, except req_ready_o=1. An in-flight op is dropped with no response.

## Timing
- Accept at edge k → enable high from cycle k+1.
- Done sampled at edge d → rsp_valid_o high from cycle d+1.
- With the 7-stage multiplier: accept to rsp_valid_o is 8 cycles.
- Special-case divide: rsp_valid_o high the cycle after accept, i.e. 1-cycle latency.
- Throughput: one op per (unit latency + 2) cycles when rsp_ready_i is tied high.
- No combinational path from any input to req_ready_o or rsp_valid_o.

## Structure
- muldiv_pkg:
  - funct3 enum: MUL…REMU
  - state enum
  - constants INT_MIN=0x80000000 and ALL_ONES
- Sub-module muldiv_div_special: combinational. Takes funct3 and the two operands; outputs is_special and special_result.
- Everything else, FSM and latches, lives in muldiv_ctrl.

## Test plan
- MUL 0x80000001×0x80010002, 7-cycle mock multiplier → rsp 0x80010002. mul_signed_a/b=1, upper=0. rsp_valid_o rises exactly 8 cycles after accept.
- MULHU, same operands → rsp 0x40008001. Signals are signed_a=0, signed_b=0, upper=1. Operands stay stable for the whole MUL_RUN.
- DIVU 0x1234/0 → rsp 0xFFFFFFFF one cycle after accept; REMU 0x1234/0 → 0x1234; div_en_o never high in either case.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0. Both take 1-cycle latency.
- Mock divider never asserts done → rsp_err_o=1, result 0 after TIMEOUT_CYC cycles. The next accepted MUL completes normally.
- rst_i pulsed during MUL_RUN → all outputs 0 and req_ready_o=1 immediately, with no rsp_valid_o. rsp_ready_i held low for 5 cycles in RESP → result and tag held stable, req_ready_o stays 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    // Multiplier mode bits are only meaningful for funct3[2]=0 and read 0 otherwise.
    function automatic logic [2:0] mul_mode(input logic [2:0] f3);
        logic sa, sb, up;
        sa = (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU);
        sb = (f3 == F3_MUL) || (f3 == F3_MULH);
        up = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
        return {sa, sb, up};
    endfunction

    function automatic logic [1:0] div_mode(input logic [2:0] f3);
        logic sg, rm;
        sg = (f3 == F3_DIV) || (f3 == F3_REM);
        rm = (f3 == F3_REM) || (f3 == F3_REMU);
        return {sg, rm};
    endfunction

endpackage

// File: rtl/muldiv_div_special.sv
// Detects RISC-V divide corner cases (x/0, INT_MIN/-1) and produces their architected result.
module muldiv_div_special
    import muldiv_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        is_special_o,
    output logic [31:0] special_result_o
);

    logic is_div;
    logic is_rem;
    logic is_signed;
    logic b_zero;
    logic overflow;

    assign is_div    = funct3_i[2];
    assign is_rem    = (funct3_i == F3_REM) || (funct3_i == F3_REMU);
    assign is_signed = (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    assign b_zero    = (op_b_i == 32'd0);
    assign overflow  = is_signed && (op_a_i == INT_MIN) && (op_b_i == ALL_ONES);

    assign is_special_o = is_div && (b_zero || overflow);

    always_comb begin
        special_result_o = 32'd0;
        if (b_zero) begin
            special_result_o = is_rem ? op_a_i : ALL_ONES;
        end else if (overflow) begin
            special_result_o = is_rem ? 32'd0 : INT_MIN;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// One-at-a-time RV32M sequencer: drives the multiplier or divider, resolves divide corner
// cases locally and aborts with an error if the selected unit never reports done.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TAG_W       = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_funct3_i,
    input  logic [31:0]      req_op_a_i,
    input  logic [31:0]      req_op_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o,
    output logic             mul_en_o,
    output logic             mul_signed_a_o,
    output logic             mul_signed_b_o,
    output logic             mul_upper_o,
    output logic [31:0]      mul_op_a_o,
    output logic [31:0]      mul_op_b_o,
    input  logic [31:0]      mul_result_i,
    input  logic             mul_done_i,
    output logic             div_en_o,
    output logic             div_signed_o,
    output logic             div_rem_o,
    output logic [31:0]      div_op_a_o,
    output logic [31:0]      div_op_b_o,
    input  logic [31:0]      div_result_i,
    input  logic             div_done_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        op_a_q, op_b_q, result_q;
    logic [TAG_W-1:0]   tag_q;
    logic               err_q;
    logic [2:0]         mul_mode_q;
    logic [1:0]         div_mode_q;

    logic               accept;
    logic               timeout;
    logic               is_special;
    logic [31:0]        special_result;

    muldiv_div_special u_special (
        .funct3_i         (req_funct3_i),
        .op_a_i           (req_op_a_i),
        .op_b_i           (req_op_b_i),
        .is_special_o     (is_special),
        .special_result_o (special_result)
    );

    assign accept  = req_valid_i && (state_q == ST_IDLE);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (!req_funct3_i[2]) begin
                        state_d = ST_MUL_RUN;
                    end else if (is_special) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_DIV_RUN;
                    end
                end
            end
            ST_MUL_RUN: if (mul_done_i || timeout) state_d = ST_RESP;
            ST_DIV_RUN: if (div_done_i || timeout) state_d = ST_RESP;
            ST_RESP:    if (rsp_ready_i) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Handshake and enables decode from state only, so no input reaches them combinationally.
    always_comb begin
        req_ready_o = 1'b0;
        mul_en_o    = 1'b0;
        div_en_o    = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            ST_IDLE:    req_ready_o = 1'b1;
            ST_MUL_RUN: mul_en_o    = 1'b1;
            ST_DIV_RUN: div_en_o    = 1'b1;
            ST_RESP:    rsp_valid_o = 1'b1;
            default:    req_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            tag_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            mul_mode_q <= '0;
            div_mode_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q      <= '0;
                        op_a_q     <= req_op_a_i;
                        op_b_q     <= req_op_b_i;
                        tag_q      <= req_tag_i;
                        err_q      <= 1'b0;
                        mul_mode_q <= mul_mode(req_funct3_i);
                        div_mode_q <= div_mode(req_funct3_i);
                        if (is_special) result_q <= special_result;
                    end
                end
                ST_MUL_RUN, ST_DIV_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if ((state_q == ST_MUL_RUN) ? mul_done_i : div_done_i) begin
                        result_q <= (state_q == ST_MUL_RUN) ? mul_result_i : div_result_i;
                        err_q    <= 1'b0;
                    end else if (timeout) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_signed_a_o = mul_mode_q[2];
    assign mul_signed_b_o = mul_mode_q[1];
    assign mul_upper_o    = mul_mode_q[0];
    assign mul_op_a_o     = op_a_q;
    assign mul_op_b_o     = op_b_q;
    assign div_signed_o   = div_mode_q[1];
    assign div_rem_o      = div_mode_q[0];
    assign div_op_a_o     = op_a_q;
    assign div_op_b_o     = op_b_q;
    assign rsp_result_o   = result_q;
    assign rsp_tag_o      = tag_q;
    assign rsp_err_o      = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed and randomized checks of muldiv_ctrl against mock units and an arithmetic reference.
module tb_muldiv_ctrl;

    localparam int TAG_W       = 5;
    localparam int TIMEOUT_CYC = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [2:0]       req_funct3;
    logic [31:0]      req_op_a, req_op_b;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             mul_en, mul_sa, mul_sb, mul_up, mul_done;
    logic [31:0]      mul_a, mul_b, mul_result;
    logic             div_en, div_sg, div_rm, div_done;
    logic [31:0]      div_a, div_b, div_result;

    int checks = 0;
    int errors = 0;

    logic div_hang = 1'b0;
    logic spur_div = 1'b0;
    logic [2:0] mcnt, dcnt;

    always #5 clk = ~clk;

    muldiv_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_funct3_i(req_funct3),
        .req_op_a_i(req_op_a), .req_op_b_i(req_op_b), .req_tag_i(req_tag),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err),
        .mul_en_o(mul_en), .mul_signed_a_o(mul_sa), .mul_signed_b_o(mul_sb), .mul_upper_o(mul_up),
        .mul_op_a_o(mul_a), .mul_op_b_o(mul_b), .mul_result_i(mul_result), .mul_done_i(mul_done),
        .div_en_o(div_en), .div_signed_o(div_sg), .div_rem_o(div_rm),
        .div_op_a_o(div_a), .div_op_b_o(div_b), .div_result_i(div_result), .div_done_i(div_done)
    );

    // Mock 7-cycle multiplier and 4-cycle divider, both driven by the DUT's mode lines.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt <= '0;
            dcnt <= '0;
        end else begin
            mcnt <= mul_en ? mcnt + 3'd1 : 3'd0;
            dcnt <= div_en ? dcnt + 3'd1 : 3'd0;
        end
    end

    logic [63:0] m_ea, m_eb, m_prod;
    always_comb begin
        m_ea       = mul_sa ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
        m_eb       = mul_sb ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
        m_prod     = m_ea * m_eb;
        mul_result = mul_up ? m_prod[63:32] : m_prod[31:0];
        mul_done   = mul_en && (mcnt == 3'd6);
    end

    always_comb begin
        div_result = 32'hDEAD_BEEF;
        if (div_en && div_b != 32'd0) begin
            if (div_sg) div_result = div_rm ? 32'($signed(div_a) % $signed(div_b))
                                            : 32'($signed(div_a) / $signed(div_b));
            else        div_result = div_rm ? div_a % div_b : div_a / div_b;
        end
        div_done = spur_div || (div_en && dcnt == 3'd3 && !div_hang);
    end

    // Reference model: RV32M semantics straight from the instruction definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p = '0;
        q = 0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = sa / sb; p = q; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6: begin
                if (b == 0) return a;
                q = sa % sb; p = q; return p[31:0];
            end
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Expected mode lines, indexed by funct3.
    bit exp_sa [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    bit exp_sb [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    bit exp_up [8] = '{0, 1, 1, 1, 0, 0, 0, 0};
    bit exp_sg [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    bit exp_rm [8] = '{0, 0, 0, 0, 0, 0, 1, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mul_ctrl", {28'd0, mul_en, mul_sa, mul_sb, mul_up}, 32'd0);
        check("rst_div_ctrl", {29'd0, div_en, div_sg, div_rm}, 32'd0);
        check("rst_operands", mul_a | mul_b | div_a | div_b, 32'd0);
    endtask

    // Issue one op, check latency, modes, operand stability, response and hold behaviour.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input bit exp_err, input int hold);
        int lat, exp_lat;
        bit saw_div, unstable;
        logic [31:0] exp_res;
        exp_res = exp_err ? 32'd0 : ref_model(f3, a, b);
        if (exp_err)                     exp_lat = TIMEOUT_CYC + 1;
        else if (!f3[2])                 exp_lat = 8;
        else if (ref_special(f3, a, b))  exp_lat = 1;
        else                             exp_lat = 5;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_funct3 = f3; req_op_a = a; req_op_b = b; req_tag = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op_a = $urandom; req_op_b = $urandom;
        lat = 1; saw_div = 0; unstable = 0;
        if (!f3[2]) begin
            check("mul_modes", {29'd0, mul_sa, mul_sb, mul_up}, {29'd0, exp_sa[f3], exp_sb[f3], exp_up[f3]});
        end else if (exp_lat != 1) begin
            check("div_modes", {30'd0, div_sg, div_rm}, {30'd0, exp_sg[f3], exp_rm[f3]});
        end
        while (rsp_valid !== 1'b1 && lat < 200) begin
            if (div_en) saw_div = 1;
            if ((mul_en || div_en) && (mul_a !== a || mul_b !== b || div_a !== a || div_b !== b)) unstable = 1;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("operands_stable", 32'(unstable), 32'd0);
        if (exp_lat == 1) check("no_div_en", 32'(saw_div), 32'd0);
        check("result", rsp_result, exp_res);
        check("tag", 32'(rsp_tag), 32'(tag));
        check("err", 32'(rsp_err), 32'(exp_err));
        $display("op f3=%0d a=%h b=%h tag=%0d -> result=%h err=%0d latency=%0d",
                 f3, a, b, tag, rsp_result, rsp_err, lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_result", rsp_result, exp_res);
            check("hold_tag", 32'(rsp_tag), 32'(tag));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("back_idle", 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit saw_valid;
        logic [2:0] f3;
        logic [31:0] a, b;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_funct3 = '0; req_op_a = '0; req_op_b = '0; req_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk); rst = 1'b0;

        spur_div = 1'b1;
        run_op(3'd0, 32'h8000_0001, 32'h8001_0002, 5'd3, 1'b0, 0);
        spur_div = 1'b0;
        check("mul_const", ref_model(3'd0, 32'h8000_0001, 32'h8001_0002), 32'h8001_0002);
        run_op(3'd3, 32'h8000_0001, 32'h8001_0002, 5'd7, 1'b0, 1);
        check("mulhu_const", ref_model(3'd3, 32'h8000_0001, 32'h8001_0002), 32'h4000_8001);
        run_op(3'd5, 32'h0000_1234, 32'd0, 5'd9, 1'b0, 0);
        run_op(3'd7, 32'h0000_1234, 32'd0, 5'd10, 1'b0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0, 0);
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd13, 1'b0, 5);

        div_hang = 1'b1;
        run_op(3'd4, 32'd100, 32'd7, 5'd14, 1'b1, 0);
        div_hang = 1'b0;
        run_op(3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 5'd15, 1'b0, 0);

        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'd0; req_op_a = 32'd5; req_op_b = 32'd6; req_tag = 5'd21;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk); rst = 1'b0;
        saw_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) saw_valid = 1;
        end
        check("no_rsp_after_rst", 32'(saw_valid), 32'd0);
        $display("reset mid-op: dropped op, rsp_valid seen=%0d", saw_valid);

        for (int n = 0; n < 24; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(f3, a, b, 5'($urandom), 1'b0, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
